ship_input_ctrl: RTL and testbench

SHIP_INPUT_CTRL -- requirements
Module: ship_input_ctrl

---
 rtl/asteroids_pkg.sv | 14 +
 rtl/ship_input_ctrl_if.sv | 28 ++
 rtl/rise_detect.sv | 23 ++
 rtl/ship_input_ctrl.sv | 97 +++++++++
 tb/tb_ship_input_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/asteroids_pkg.sv
// Shared game constants and encodings for the ship input controller.
package asteroids_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } game_state_e;

    localparam int HEADING_W             = 4;
    localparam int ROT_PERIOD_DEFAULT    = 4;
    localparam int FIRE_COOLDOWN_DEFAULT = 8;
    localparam int ROT_CNT_W             = 4;
    localparam int COOLDOWN_W            = 8;
endpackage

// File: rtl/ship_input_ctrl_if.sv
// Key levels and game pulses into the ship controller, ship state out.
interface ship_input_ctrl_if;
    import asteroids_pkg::*;

    // There is no back-pressure: fire is a one-cycle strobe that is accepted
    // by the game logic in the cycle it is high; all other outputs are levels.
    logic                 left;
    logic                 right;
    logic                 up;
    logic                 space;
    logic                 enter;
    logic                 frame_tick;
    logic                 game_over;
    logic [1:0]           game_state;
    logic [HEADING_W-1:0] heading;
    logic                 thrust;
    logic                 fire;

    modport master (
        output left, right, up, space, enter, frame_tick, game_over,
        input  game_state, heading, thrust, fire
    );

    modport slave (
        input  left, right, up, space, enter, frame_tick, game_over,
        output game_state, heading, thrust, fire
    );
endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector; a level already high when reset is released is not an edge.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic prev_q;
    logic armed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= in;
            armed_q <= 1'b1;
        end
    end

    // armed_q masks the first cycle after reset, before prev_q holds a real level
    assign pulse = armed_q && in && !prev_q;
endmodule

// File: rtl/ship_input_ctrl.sv
// Game mode FSM plus heading, thrust and fire control driven by held keys.
module ship_input_ctrl
    import asteroids_pkg::*;
#(
    parameter int ROT_PERIOD    = ROT_PERIOD_DEFAULT,
    parameter int FIRE_COOLDOWN = FIRE_COOLDOWN_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    ship_input_ctrl_if.slave  bus
);
    localparam logic [ROT_CNT_W-1:0]  ROT_LAST = ROT_CNT_W'(ROT_PERIOD - 1);
    localparam logic [COOLDOWN_W-1:0] CD_LOAD  = COOLDOWN_W'(FIRE_COOLDOWN);

    game_state_e           state_q;
    game_state_e           state_d;
    logic                  enter_edge;
    logic                  space_edge;
    logic [HEADING_W-1:0]  heading_q;
    logic [ROT_CNT_W-1:0]  rot_cnt_q;
    logic [COOLDOWN_W-1:0] cooldown_q;
    logic                  last_right_q;
    logic                  thrust_q;
    logic                  fire_q;

    rise_detect u_enter_rise (.clock(clock), .reset(reset), .in(bus.enter), .pulse(enter_edge));
    rise_detect u_space_rise (.clock(clock), .reset(reset), .in(bus.space), .pulse(space_edge));

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // game_over outranks enter while playing
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enter_edge) state_d = PLAY;
            PLAY:    if (bus.game_over) state_d = IDLE;
                     else if (enter_edge) state_d = PAUSE;
            PAUSE:   if (enter_edge) state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.game_state = state_q;
        bus.heading    = heading_q;
        bus.thrust     = thrust_q;
        bus.fire       = fire_q;
    end

    logic                 play;
    logic                 rot_tick;
    logic                 single_key;
    logic                 dir_right;
    logic                 fire_ok;
    logic [ROT_CNT_W-1:0] rot_phase;

    // A change of direction restarts the rotate phase so the first step is immediate
    always_comb begin
        play       = (state_q == PLAY);
        rot_tick   = play && bus.frame_tick;
        single_key = bus.left ^ bus.right;
        dir_right  = bus.right;
        fire_ok    = play && space_edge && (cooldown_q == '0);
        rot_phase  = (dir_right != last_right_q) ? '0 : rot_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset || state_d == IDLE) begin
            heading_q    <= '0;
            rot_cnt_q    <= '0;
            cooldown_q   <= '0;
            last_right_q <= 1'b0;
            thrust_q     <= 1'b0;
            fire_q       <= 1'b0;
        end else begin
            thrust_q <= bus.up && play;
            fire_q   <= fire_ok;
            if (fire_ok)
                cooldown_q <= CD_LOAD;
            else if (rot_tick && cooldown_q != '0)
                cooldown_q <= cooldown_q - 1'b1;
            if (rot_tick) begin
                if (single_key) begin
                    last_right_q <= dir_right;
                    if (rot_phase == '0)
                        heading_q <= dir_right ? heading_q - 1'b1 : heading_q + 1'b1;
                    rot_cnt_q <= (rot_phase == ROT_LAST) ? '0 : rot_phase + 1'b1;
                end else begin
                    rot_cnt_q <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ship_input_ctrl.sv
// Directed scoreboard bench for ship_input_ctrl (ROT_PERIOD=4, FIRE_COOLDOWN=8).
module tb_ship_input_ctrl;
    localparam int W = 7;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   done;
    bit   final_checked;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           fire_exp_q[$];

    ship_input_ctrl_if bus();

    ship_input_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(2);
    endtask

    task automatic press_enter();
        bus.enter = 1'b1;
        step(1);
        bus.enter = 1'b0;
        step(1);
    endtask

    task automatic press_space(input bit expect_fire);
        bus.space = 1'b1;
        if (expect_fire) fire_exp_q.push_back(cyc + 1);
        step(1);
        bus.space = 1'b0;
        step(1);
    endtask

    task automatic expect_now(input string name, input logic [1:0] st,
                              input logic [3:0] hd, input logic th);
        exp_q.push_back({st, hd, th});
        name_q.push_back(name);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        string        nm;
        int           fe;
        if (bus.fire) begin
            checks++;
            if (fire_exp_q.size() == 0) begin
                errors++;
                $display("FAIL fire_unexpected at cycle %0d (no fire expected)", cyc);
            end else begin
                fe = fire_exp_q.pop_front();
                if (fe != cyc) begin
                    errors++;
                    $display("FAIL fire_cycle got cycle %0d expected cycle %0d", cyc, fe);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {bus.game_state, bus.heading, bus.thrust};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s got state=%0d heading=%0d thrust=%0d expected state=%0d heading=%0d thrust=%0d",
                         nm, got[6:5], got[4:1], got[0], e[6:5], e[4:1], e[0]);
            end
        end
        if (done && !final_checked) begin
            final_checked = 1'b1;
            checks++;
            if (fire_exp_q.size() != 0) begin
                errors++;
                $display("FAIL fire_missing got %0d pending expected 0 pending", fire_exp_q.size());
            end
        end
    end

    initial begin
        int down_exp[4];
        down_exp = '{2, 1, 0, 15};
        checks = 0; errors = 0; done = 1'b0; final_checked = 1'b0;
        reset = 1'b1;
        bus.left = 1'b0; bus.right = 1'b0; bus.up = 1'b0; bus.space = 1'b0;
        bus.enter = 1'b0; bus.frame_tick = 1'b0; bus.game_over = 1'b0;

        step(3);
        expect_now("reset_state", 2'd0, 4'd0, 1'b0);
        reset = 1'b0;
        step(2);
        expect_now("idle_after_reset", 2'd0, 4'd0, 1'b0);

        // enter edge, then held enter must not toggle again
        bus.enter = 1'b1;
        step(1);
        expect_now("enter_idle_to_play", 2'd1, 4'd0, 1'b0);
        step(100);
        expect_now("enter_held_no_toggle", 2'd1, 4'd0, 1'b0);
        bus.enter = 1'b0;
        step(1);

        bus.up = 1'b1;
        step(1);
        expect_now("thrust_on", 2'd1, 4'd0, 1'b1);
        bus.up = 1'b0;
        step(1);
        expect_now("thrust_off", 2'd1, 4'd0, 1'b0);

        // left held over 9 ticks: steps at ticks 1, 5 and 9
        bus.left = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            expect_now($sformatf("left_tick%0d", k), 2'd1, 4'(1 + (k - 1) / 4), 1'b0);
        end
        bus.left = 1'b0;
        tick();
        expect_now("no_key_tick", 2'd1, 4'd3, 1'b0);

        for (int k = 0; k < 4; k++) begin
            bus.right = 1'b1;
            tick();
            bus.right = 1'b0;
            tick();
            expect_now($sformatf("right_press%0d", k), 2'd1, 4'(down_exp[k]), 1'b0);
        end
        bus.left = 1'b1;
        tick();
        bus.left = 1'b0;
        tick();
        expect_now("wrap_up", 2'd1, 4'd0, 1'b0);
        bus.left = 1'b1; bus.right = 1'b1;
        tick();
        tick();
        expect_now("both_held", 2'd1, 4'd0, 1'b0);
        bus.right = 1'b0;
        tick();
        expect_now("left_after_both", 2'd1, 4'd1, 1'b0);
        bus.left = 1'b0; bus.right = 1'b1;
        tick();
        expect_now("dir_switch", 2'd1, 4'd0, 1'b0);
        bus.right = 1'b0;
        tick();

        // fire and cooldown
        press_space(1'b1);
        repeat (3) tick();
        press_space(1'b0);
        repeat (4) tick();
        press_space(1'b0);
        tick();
        press_space(1'b1);
        repeat (8) tick();
        bus.space = 1'b1;
        fire_exp_q.push_back(cyc + 1);
        step(20);
        repeat (10) tick();
        bus.space = 1'b0;
        step(1);
        // space edge together with frame_tick: cooldown loads without decrementing
        bus.space = 1'b1; bus.frame_tick = 1'b1;
        fire_exp_q.push_back(cyc + 1);
        step(1);
        bus.space = 1'b0; bus.frame_tick = 1'b0;
        step(2);
        repeat (7) tick();
        press_space(1'b0);
        tick();
        press_space(1'b1);
        repeat (4) tick();

        // pause freezes heading, cooldown and thrust
        press_enter();
        expect_now("play_to_pause", 2'd2, 4'd0, 1'b0);
        bus.up = 1'b1; bus.left = 1'b1;
        repeat (10) tick();
        expect_now("pause_frozen", 2'd2, 4'd0, 1'b0);
        press_space(1'b0);
        bus.up = 1'b0; bus.left = 1'b0;
        step(1);
        press_enter();
        expect_now("pause_to_play", 2'd1, 4'd0, 1'b0);
        press_space(1'b0);
        repeat (3) tick();
        press_space(1'b0);
        tick();
        press_space(1'b1);

        // game_over beats a same-cycle enter edge
        bus.left = 1'b1;
        tick();
        bus.left = 1'b0;
        expect_now("heading_before_over", 2'd1, 4'd1, 1'b0);
        bus.game_over = 1'b1; bus.enter = 1'b1;
        step(1);
        bus.game_over = 1'b0;
        expect_now("gameover_wins", 2'd0, 4'd0, 1'b0);
        bus.enter = 1'b0;
        step(1);
        bus.game_over = 1'b1;
        step(1);
        bus.game_over = 1'b0;
        expect_now("gameover_idle_ignored", 2'd0, 4'd0, 1'b0);
        press_enter();
        expect_now("replay", 2'd1, 4'd0, 1'b0);
        press_space(1'b1);
        press_enter();
        bus.game_over = 1'b1;
        step(1);
        bus.game_over = 1'b0;
        step(1);
        expect_now("gameover_pause_ignored", 2'd2, 4'd0, 1'b0);
        press_enter();
        expect_now("resume_after_pause", 2'd1, 4'd0, 1'b0);

        // keys held across reset release give no edge
        bus.space = 1'b1; bus.enter = 1'b1;
        reset = 1'b1;
        step(3);
        expect_now("reset_again", 2'd0, 4'd0, 1'b0);
        reset = 1'b0;
        step(5);
        expect_now("held_enter_no_edge", 2'd0, 4'd0, 1'b0);
        bus.enter = 1'b0;
        step(1);
        press_enter();
        expect_now("play_with_space_held", 2'd1, 4'd0, 1'b0);
        step(5);
        bus.space = 1'b0;
        step(1);
        press_space(1'b1);
        step(5);

        done = 1'b1;
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
